// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor: opcodes, execution FSM states and
// the default datapath widths.
package simple_processor_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;

    typedef enum logic [3:0] {
        FUNC_ADD,
        FUNC_SUB,
        FUNC_AND,
        FUNC_OR,
        FUNC_XOR,
        FUNC_NOT,
        FUNC_ADDI,
        FUNC_SLL,
        FUNC_SLR,
        FUNC_SLLI,
        FUNC_SLRI,
        FUNC_LOAD,
        FUNC_STORE
    } func_t;

    typedef enum logic {
        IDLE,
        MEM
    } exec_state_t;

    function automatic logic is_mem_func(func_t f);
        return (f == FUNC_LOAD) || (f == FUNC_STORE);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execution unit. func_valid_o is low for memory
// ops and for undefined opcodes, which both yield a zero result.
module exec_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 6
) (
    input  simple_processor_pkg::func_t func_i,
    input  logic [DATA_WIDTH-1:0]       rs1_i,
    input  logic [DATA_WIDTH-1:0]       rs2_i,
    input  logic [IMM_WIDTH-1:0]        imm_i,
    output logic [DATA_WIDTH-1:0]       result_o,
    output logic                        func_valid_o
);
    import simple_processor_pkg::*;

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] imm_sext;
    logic [SHW-1:0]        rs2_shamt;
    logic [SHW-1:0]        imm_shamt;

    assign imm_sext  = {{(DATA_WIDTH-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
    assign rs2_shamt = rs2_i[SHW-1:0];
    assign imm_shamt = imm_i[SHW-1:0];

    always_comb begin
        result_o     = '0;
        func_valid_o = 1'b1;
        case (func_i)
            FUNC_ADD:  result_o = rs1_i + rs2_i;
            FUNC_SUB:  result_o = rs1_i - rs2_i;
            FUNC_AND:  result_o = rs1_i & rs2_i;
            FUNC_OR:   result_o = rs1_i | rs2_i;
            FUNC_XOR:  result_o = rs1_i ^ rs2_i;
            FUNC_NOT:  result_o = ~rs1_i;
            FUNC_ADDI: result_o = rs1_i + imm_sext;
            FUNC_SLL:  result_o = rs1_i << rs2_shamt;
            FUNC_SLR:  result_o = rs1_i >> rs2_shamt;
            FUNC_SLLI: result_o = rs1_i << imm_shamt;
            FUNC_SLRI: result_o = rs1_i >> imm_shamt;
            default:   func_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipelined_execution.sv
// Registered execution unit: single-cycle ALU results and multi-cycle
// LOAD/STORE transactions against DMEM with an optional ack timeout.
module pipelined_execution #(
    parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int IMM_WIDTH      = 6,
    parameter int RD_ADDR_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  simple_processor_pkg::func_t func_i,
    input  logic [DATA_WIDTH-1:0]       rs1_data_i,
    input  logic [DATA_WIDTH-1:0]       rs2_data_i,
    input  logic [IMM_WIDTH-1:0]        imm_i,
    input  logic [RD_ADDR_WIDTH-1:0]    rd_addr_i,
    output logic                        dmem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic                        dmem_we_o,
    output logic [MEM_DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0]   dmem_rdata_i,
    input  logic                        dmem_ack_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DATA_WIDTH-1:0]       rd_data_o,
    output logic [RD_ADDR_WIDTH-1:0]    rd_addr_o,
    output logic                        rd_we_o,
    output logic                        err_o
);
    import simple_processor_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    exec_state_t               state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic                      timeout_hit;
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     rd_data_q;
    logic [RD_ADDR_WIDTH-1:0]  rd_addr_q;
    logic                      rd_we_q;
    logic                      err_q;
    logic                      dmem_req_q;
    logic                      dmem_we_q;
    logic [MEM_ADDR_WIDTH-1:0] dmem_addr_q;
    logic [MEM_DATA_WIDTH-1:0] dmem_wdata_q;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      alu_valid;
    logic                      accept;

    exec_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_alu (
        .func_i       (func_i),
        .rs1_i        (rs1_data_i),
        .rs2_i        (rs2_data_i),
        .imm_i        (imm_i),
        .result_o     (alu_result),
        .func_valid_o (alu_valid)
    );

    assign ready_o = (state_q == IDLE) && (!valid_q || ready_i);
    assign accept  = valid_i && ready_o;
    assign cnt_d   = cnt_q + 1'b1;
    // The counter tracks request cycles already spent; the last allowed one
    // is the edge where the incremented count would reach the limit.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            err_q        <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rd_addr_q <= rd_addr_i;
                        if (is_mem_func(func_i)) begin
                            state_q      <= MEM;
                            cnt_q        <= '0;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (func_i == FUNC_STORE);
                            dmem_addr_q  <= rs1_data_i[MEM_ADDR_WIDTH-1:0];
                            dmem_wdata_q <= rs2_data_i;
                        end else begin
                            valid_q   <= 1'b1;
                            rd_data_q <= alu_result;
                            rd_we_q   <= alu_valid;
                            err_q     <= 1'b0;
                        end
                    end
                end
                MEM: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (dmem_ack_i) begin
                        state_q    <= IDLE;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        valid_q    <= 1'b1;
                        rd_data_q  <= dmem_we_q ? '0 : dmem_rdata_i;
                        rd_we_q    <= !dmem_we_q;
                        err_q      <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q    <= IDLE;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        valid_q    <= 1'b1;
                        rd_data_q  <= '0;
                        rd_we_q    <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o      = valid_q;
    assign rd_data_o    = rd_data_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_we_o      = rd_we_q;
    assign err_o        = err_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;

endmodule
